instruction_fetch: RTL

Fetch stage between `program_counter` and decode. It requests the instruction at `pc_value` from instruction memory over a variable-latency req/ack interface and holds the result in a one-entry output slot with a valid/ready handshake to decode. The PC advances every cycle, so this block stalls it with `pc_hold`/`pc_hold_address`, which the top level feeds into the PC's jump port. Downstream redirects arrive on `flush`.

---
 rtl/instruction_fetch_pkg.sv | 29 ++
 rtl/instruction_fetch_slot.sv | 42 ++++
 rtl/instruction_fetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-path definitions: FSM states, the output-slot record and the
// PC constants also used by program_counter.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } slot_entry_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR      = 32'h0000_0000;

  // Sequential successor address; wraps naturally at 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic is_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_slot.sv
// One-entry output register towards decode with valid/ready handshake.
// A flush empties the slot and wins over a load in the same cycle.
module instruction_fetch_slot
  import instruction_fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  slot_entry_t load_entry,
  input  logic        flush,
  input  logic        ready,
  output logic        valid,
  output slot_entry_t entry,
  output logic [31:0] pc_plus4,
  output logic        slot_free
);

  assign slot_free = ~valid | ready;

  // NOTE: the payload registers are reset too, because decode and the
  // program_counter observe if_instr/if_pc/if_pc_plus4 with defined values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      entry    <= '0;
      pc_plus4 <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid    <= 1'b1;
        entry    <= load_entry;
        pc_plus4 <= next_pc(load_entry.pc);
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one instruction-memory request at a time, holds the
// PC until the slot is loaded, and drops in-flight data on a flush.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_value,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_fault,
  output logic        pc_hold,
  output logic [31:0] pc_hold_address
);

  fetch_state_t state, state_next;
  logic [31:0]  req_addr, req_addr_next;
  logic         slot_free;
  logic         slot_load;
  slot_entry_t  load_entry;
  slot_entry_t  slot_entry;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_addr <= RESET_VECTOR;
    end else begin
      state    <= state_next;
      req_addr <= req_addr_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_next    = state;
    req_addr_next = req_addr;
    imem_req      = 1'b0;
    imem_addr     = req_addr;
    slot_load     = 1'b0;
    load_entry    = '{instr: imem_rdata, pc: req_addr, fault: 1'b0};

    unique case (state)
      IDLE: begin
        // Issue only into an empty slot so the ack can always be absorbed;
        // the reset gate keeps imem_req low while the block is held in reset.
        if (slot_free && !flush && !reset) begin
          if (is_aligned(pc_value)) begin
            imem_req      = 1'b1;
            imem_addr     = pc_value;
            req_addr_next = pc_value;
            state_next    = WAIT;
          end else begin
            slot_load  = 1'b1;
            load_entry = '{instr: NOP_INSTR, pc: pc_value, fault: 1'b1};
          end
        end
      end

      WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          slot_load  = ~flush;
          state_next = IDLE;
        end else if (flush) begin
          state_next = DISCARD;
        end
      end

      DISCARD: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Any cycle that neither loads the slot nor redirects re-fetches this PC.
  assign pc_hold         = ~flush & ~slot_load;
  assign pc_hold_address = pc_value;

  instruction_fetch_slot u_slot (
    .clock      (clock),
    .reset      (reset),
    .load       (slot_load),
    .load_entry (load_entry),
    .flush      (flush),
    .ready      (if_ready),
    .valid      (if_valid),
    .entry      (slot_entry),
    .pc_plus4   (if_pc_plus4),
    .slot_free  (slot_free)
  );

  assign if_instr = slot_entry.instr;
  assign if_pc    = slot_entry.pc;
  assign if_fault = slot_entry.fault;

endmodule
